// File: rtl/data_mem_responder.sv
// Fixed-latency multi-channel data memory with independent ask/get read and write channels.
// Optional access counters are enabled by defining DATA_MEM_ACCESS_COUNT_EN.
module data_mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] read_ask,
  input  logic [ADDR_BITS-1:0]    read_addr [NUM_CHANNELS],
  output logic [DATA_BITS-1:0]    read_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] read_get,
  input  logic [NUM_CHANNELS-1:0] write_ask,
  input  logic [ADDR_BITS-1:0]    write_addr [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] write_get,
  input  logic                    host_wr_en,
  input  logic [ADDR_BITS-1:0]    host_addr,
  input  logic [DATA_BITS-1:0]    host_wr_data,
  output logic [DATA_BITS-1:0]    host_rd_data
`ifdef DATA_MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]             read_count,
  output logic [15:0]             write_count
`endif
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_COOL} state_t;

  logic [DATA_BITS-1:0]    r_mem      [DEPTH];
  state_t                  r_rd_state [NUM_CHANNELS];
  logic [3:0]              r_rd_cnt   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    r_rd_addr  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    r_rd_data  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_rd_get;
  state_t                  r_wr_state [NUM_CHANNELS];
  logic [3:0]              r_wr_cnt   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    r_wr_addr  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    r_wr_data  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_wr_get;

  // Read channels: data is sampled on the edge that enters RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_rd_state[i] <= S_IDLE;
        r_rd_cnt[i]   <= '0;
        r_rd_addr[i]  <= '0;
        r_rd_data[i]  <= '0;
      end
      r_rd_get <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_rd_get[i] <= 1'b0;
        case (r_rd_state[i])
          S_IDLE: begin
            if (read_ask[i]) begin
              r_rd_addr[i] <= read_addr[i];
              r_rd_cnt[i]  <= CNT_INIT;
              if (LATENCY == 1) begin
                r_rd_state[i] <= S_RESP;
                r_rd_get[i]   <= 1'b1;
                r_rd_data[i]  <= r_mem[read_addr[i]];
              end else begin
                r_rd_state[i] <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (r_rd_cnt[i] <= 4'd1) begin
              r_rd_state[i] <= S_RESP;
              r_rd_get[i]   <= 1'b1;
              r_rd_data[i]  <= r_mem[r_rd_addr[i]];
            end else begin
              r_rd_cnt[i] <= r_rd_cnt[i] - 4'd1;
            end
          end
          S_RESP:  r_rd_state[i] <= S_COOL;
          default: r_rd_state[i] <= S_IDLE;
        endcase
      end
    end
  end

  // Write channels: the commit happens in the storage block while in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_wr_state[i] <= S_IDLE;
        r_wr_cnt[i]   <= '0;
        r_wr_addr[i]  <= '0;
        r_wr_data[i]  <= '0;
      end
      r_wr_get <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_wr_get[i] <= 1'b0;
        case (r_wr_state[i])
          S_IDLE: begin
            if (write_ask[i]) begin
              r_wr_addr[i] <= write_addr[i];
              r_wr_data[i] <= write_data[i];
              r_wr_cnt[i]  <= CNT_INIT;
              if (LATENCY == 1) begin
                r_wr_state[i] <= S_RESP;
                r_wr_get[i]   <= 1'b1;
              end else begin
                r_wr_state[i] <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (r_wr_cnt[i] <= 4'd1) begin
              r_wr_state[i] <= S_RESP;
              r_wr_get[i]   <= 1'b1;
            end else begin
              r_wr_cnt[i] <= r_wr_cnt[i] - 4'd1;
            end
          end
          S_RESP:  r_wr_state[i] <= S_COOL;
          default: r_wr_state[i] <= S_IDLE;
        endcase
      end
    end
  end

  // Later assignments win: host first, then channels from highest to lowest index.
  always_ff @(posedge clk) begin
    if (host_wr_en) r_mem[host_addr] <= host_wr_data;
    if (!reset) begin
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
        if (r_wr_state[i] == S_RESP) r_mem[r_wr_addr[i]] <= r_wr_data[i];
      end
    end
  end

  assign read_data    = r_rd_data;
  assign read_get     = r_rd_get;
  assign write_get    = r_wr_get;
  assign host_rd_data = r_mem[host_addr];

`ifdef DATA_MEM_ACCESS_COUNT_EN
  logic [15:0] r_read_count;
  logic [15:0] r_write_count;
  logic [16:0] w_rd_sum;
  logic [16:0] w_wr_sum;

  always_comb begin
    w_rd_sum = {1'b0, r_read_count};
    w_wr_sum = {1'b0, r_write_count};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_rd_sum = w_rd_sum + 17'(r_rd_get[i]);
      w_wr_sum = w_wr_sum + 17'(r_wr_get[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      r_read_count  <= w_rd_sum[16] ? 16'hFFFF : w_rd_sum[15:0];
      r_write_count <= w_wr_sum[16] ? 16'hFFFF : w_wr_sum[15:0];
    end
  end

  assign read_count  = r_read_count;
  assign write_count = r_write_count;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance for the main traffic
// and a LATENCY=1 instance for the held-ask spacing test.
module tb_data_mem_responder;
  localparam int NCH = 4;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (LATENCY=2) ----------------
  logic [NCH-1:0] read_ask, read_get, write_ask, write_get;
  logic [7:0]     read_addr [NCH];
  logic [7:0]     read_data [NCH];
  logic [7:0]     write_addr [NCH];
  logic [7:0]     write_data [NCH];
  logic           host_wr_en;
  logic [7:0]     host_addr, host_wr_data, host_rd_data;
`ifdef DATA_MEM_ACCESS_COUNT_EN
  logic [15:0]    read_count, write_count;
  logic [15:0]    read_count1, write_count1;
`endif

  data_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(NCH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .read_ask(read_ask), .read_addr(read_addr), .read_data(read_data), .read_get(read_get),
    .write_ask(write_ask), .write_addr(write_addr), .write_data(write_data), .write_get(write_get),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wr_data(host_wr_data),
    .host_rd_data(host_rd_data)
`ifdef DATA_MEM_ACCESS_COUNT_EN
    , .read_count(read_count), .write_count(write_count)
`endif
  );

  // ---------------- second DUT (LATENCY=1) ----------------
  logic [NCH-1:0] read_ask1, read_get1, write_ask1, write_get1;
  logic [7:0]     read_addr1 [NCH];
  logic [7:0]     read_data1 [NCH];
  logic [7:0]     write_addr1 [NCH];
  logic [7:0]     write_data1 [NCH];
  logic           host_wr_en1;
  logic [7:0]     host_addr1, host_wr_data1, host_rd_data1;

  data_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(NCH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .read_ask(read_ask1), .read_addr(read_addr1), .read_data(read_data1), .read_get(read_get1),
    .write_ask(write_ask1), .write_addr(write_addr1), .write_data(write_data1), .write_get(write_get1),
    .host_wr_en(host_wr_en1), .host_addr(host_addr1), .host_wr_data(host_wr_data1),
    .host_rd_data(host_rd_data1)
`ifdef DATA_MEM_ACCESS_COUNT_EN
    , .read_count(read_count1), .write_count(write_count1)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [23:0] rd_q [NCH][$];   // {expected get cycle, expected data}
  logic [15:0] wr_q [NCH][$];   // expected get cycle
  logic [7:0]  model [256];
  logic [23:0] rd_e;
  logic [15:0] wr_e;
  int          n_rd_seen = 0;
  int          n_wr_seen = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (read_get[i] !== 1'b0) begin
        n_rd_seen++;
        if (rd_q[i].size() == 0) begin
          check_val("rd_spurious", 32'(read_get[i]), 32'd0);
        end else begin
          rd_e = rd_q[i].pop_front();
          check_val("rd_cycle", cyc, 32'(rd_e[23:8]));
          check_val("rd_data", 32'(read_data[i]), 32'(rd_e[7:0]));
        end
      end
      if (write_get[i] !== 1'b0) begin
        n_wr_seen++;
        if (wr_q[i].size() == 0) begin
          check_val("wr_spurious", 32'(write_get[i]), 32'd0);
        end else begin
          wr_e = wr_q[i].pop_front();
          check_val("wr_cycle", cyc, 32'(wr_e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    host_addr    = a;
    host_wr_data = d;
    host_wr_en   = 1'b1;
    tick();
    host_wr_en   = 1'b0;
    model[a]     = d;
  endtask

  task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] exp);
    host_addr = a;
    #1;
    check_val(tag, 32'(host_rd_data), 32'(exp));
  endtask

  task automatic rd_req(input int ch, input logic [7:0] a);
    read_ask[ch]  = 1'b1;
    read_addr[ch] = a;
    rd_q[ch].push_back({16'(cyc + LAT), model[a]});
  endtask

  task automatic wr_req(input int ch, input logic [7:0] a, input logic [7:0] d);
    write_ask[ch]  = 1'b1;
    write_addr[ch] = a;
    write_data[ch] = d;
    wr_q[ch].push_back(16'(cyc + LAT));
  endtask

  // One accept edge, then asks drop; the requests must still complete.
  task automatic issue_done();
    tick();
    read_ask  = '0;
    write_ask = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int held_cyc [$];
  logic [7:0] ra;

  initial begin
    reset = 1'b1;
    read_ask = '0; write_ask = '0; host_wr_en = 1'b0; host_addr = '0; host_wr_data = '0;
    read_ask1 = '0; write_ask1 = '0; host_wr_en1 = 1'b0; host_addr1 = '0; host_wr_data1 = '0;
    for (int i = 0; i < NCH; i++) begin
      read_addr[i] = '0; write_addr[i] = '0; write_data[i] = '0;
      read_addr1[i] = '0; write_addr1[i] = '0; write_data1[i] = '0;
    end
    idle(3);
    check_val("rst_read_get", 32'(read_get), 32'd0);
    check_val("rst_write_get", 32'(write_get), 32'd0);
    for (int i = 0; i < NCH; i++) check_val("rst_read_data", 32'(read_data[i]), 32'd0);
    reset = 1'b0;
    tick();

    // Preload and single read
    host_wr(8'h10, 8'h5A);
    peek("preload_peek", 8'h10, 8'h5A);
    rd_req(0, 8'h10);
    issue_done();
    idle(4);

    // Four parallel reads in one cycle
    for (int i = 0; i < NCH; i++) host_wr(8'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < NCH; i++) rd_req(i, 8'(i));
    issue_done();
    idle(4);

    // Same-address write collision: lowest channel wins
    wr_req(1, 8'h20, 8'hAA);
    wr_req(3, 8'h20, 8'hBB);
    issue_done();
    idle(4);
    peek("collision", 8'h20, 8'hAA);
    model[8'h20] = 8'hAA;

    // Read/write race returns the pre-write value
    host_wr(8'h30, 8'h01);
    rd_req(2, 8'h30);
    wr_req(0, 8'h30, 8'h02);
    issue_done();
    idle(4);
    model[8'h30] = 8'h02;
    peek("race_commit", 8'h30, 8'h02);
    rd_req(2, 8'h30);
    issue_done();
    idle(4);

    // Reset right after a write is accepted: dropped, never committed
    host_wr(8'h40, 8'h00);
    write_ask[0]  = 1'b1;
    write_addr[0] = 8'h40;
    write_data[0] = 8'h77;
    issue_done();
    reset = 1'b1;
    n_rd_seen = 0;
    n_wr_seen = 0;
    repeat (3) begin
      tick();
      check_val("midrst_read_get", 32'(read_get), 32'd0);
      check_val("midrst_write_get", 32'(write_get), 32'd0);
    end
    reset = 1'b0;
    idle(5);
    peek("midrst_no_commit", 8'h40, 8'h00);

    // Random multi-channel reads over a randomly preloaded window
    for (int a = 8'h80; a < 8'h90; a++) host_wr(8'(a), 8'($urandom_range(0, 255)));
    for (int it = 0; it < 20; it++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 1) == 1) begin
          ra = 8'($urandom_range(8'h80, 8'h8F));
          rd_req(ch, ra);
        end
      end
      issue_done();
      idle(LAT + 1);
    end
    idle(4);

    // Held ask on the LATENCY=1 instance: gets every LATENCY+2 = 3 cycles
    host_addr1    = 8'h05;
    host_wr_data1 = 8'hC3;
    host_wr_en1   = 1'b1;
    tick();
    host_wr_en1   = 1'b0;
    read_addr1[0] = 8'h05;
    read_ask1[0]  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (read_get1[0] === 1'b1) begin
        held_cyc.push_back(cyc);
        check_val("held_data", 32'(read_data1[0]), 32'h0000_00C3);
      end
    end
    read_ask1[0] = 1'b0;
    idle(3);
    check_val("held_count_ok", 32'(held_cyc.size() >= 4), 32'd1);
    for (int k = 1; k < held_cyc.size(); k++)
      check_val("held_spacing", 32'(held_cyc[k] - held_cyc[k-1]), 32'd3);

    // Every pushed expectation must have been consumed
    for (int i = 0; i < NCH; i++) begin
      check_val("rd_q_empty", 32'(rd_q[i].size()), 32'd0);
      check_val("wr_q_empty", 32'(wr_q[i].size()), 32'd0);
    end
`ifdef DATA_MEM_ACCESS_COUNT_EN
    check_val("read_count", 32'(read_count), 32'(n_rd_seen));
    check_val("write_count", 32'(write_count), 32'(n_wr_seen));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Fixed-latency data memory that sits directly downstream of the GPU top level's data memory channel ports.
- Serves DATA_MEM_NUM_CHANNELS independent read and write channels over the ask/get handshake.
- Backed by one shared storage array. A host preload/peek port lets benches and the SoC load inputs and read results.
- Used as the standard memory model in system simulation and as the on-chip scratch memory in FPGA builds.

Parameters:
- ADDR_BITS, 8, address width; storage depth is 2**ADDR_BITS words.
- DATA_BITS, 8, word width.
- NUM_CHANNELS, 4, number of read channels and number of write channels.
- LATENCY, 2, cycles from request acceptance to get; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- read_ask  in  NUM_CHANNELS  per-channel read request.
- read_addr  in  ADDR_BITS x NUM_CHANNELS (unpacked)  read address.
- read_data  out  DATA_BITS x NUM_CHANNELS (unpacked)  read result; valid while read_get is high.
- read_get  out  NUM_CHANNELS  read response strobe.
- write_ask  in  NUM_CHANNELS  per-channel write request.
- write_addr  in  ADDR_BITS x NUM_CHANNELS (unpacked)  write address.
- write_data  in  DATA_BITS x NUM_CHANNELS (unpacked)  write data.
- write_get  out  NUM_CHANNELS  write acknowledge strobe.
- host_wr_en  in  1  host preload write.
- host_addr  in  ADDR_BITS  host address.
- host_wr_data  in  DATA_BITS  host write data.
- host_rd_data  out  DATA_BITS  combinational read of mem[host_addr].

Behaviour:
- Reset (async, active-high):
  - All channel FSMs go to IDLE.
  - read_get=0, write_get=0, read_data=0 for every channel.
  - Storage contents are NOT reset.
- Per-channel FSM, one FSM per read channel and one per write channel, each independent:
  - IDLE: ask=1 → latch the address (and data for writes), load cnt=LATENCY-1, go to WAIT. Acceptance cycle is T.
  - WAIT: cnt decrements each cycle; at cnt==0 go to RESP. With LATENCY=1, WAIT lasts zero cycles and the FSM goes IDLE→RESP directly.
  - RESP: get=1 for exactly one cycle, the cycle after T+LATENCY-1, so get is observed high at cycle T+LATENCY.
    - Read: read_data = mem[latched addr], sampled into a register on the RESP entry edge.
    - Write: mem[latched addr] <= latched data on the RESP exit edge.
    - Next state: COOL.
  - COOL: one cycle, ask ignored (the requester drops ask after seeing get); go to IDLE.
- Minimum request period is therefore LATENCY+2 cycles.
- ask deasserted during WAIT: the request still completes, get still pulses, and the write is still committed. Requests are never cancelled.
- read_data holds its last value after RESP; only its value while read_get=1 is guaranteed.
- Address/data changes after acceptance are ignored, because they were latched at T.
- Same-cycle write commits to the same address from multiple channels: the lowest channel index wins.
- Host write vs channel write to the same address in the same cycle: the channel write wins.
- Read/write same address, same cycle: a read whose data is sampled on the same edge a write commits returns the pre-write value.
- host_rd_data is purely combinational from the current storage contents.
- Reset asserted mid-request: in-flight requests are dropped, no get is issued, and a pending write is not committed.

Optional Feature:
- Macro: DATA_MEM_ACCESS_COUNT_EN.
- Defined:
  - Adds outputs read_count[15:0] and write_count[15:0].
  - Each counts get pulses (all channels summed per cycle, +0..NUM_CHANNELS).
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Preload: host writes mem[0x10]=0x5A; channel 0 read_ask at T with addr 0x10, LATENCY=2 → read_get[0]=1 only at T+2 with read_data[0]=0x5A; no get at T+3.
- Parallel reads: all 4 channels read addrs 0x00..0x03 (preloaded 0x11,0x22,0x33,0x44) in the same cycle → all four gets are high in the same cycle with the matching data.
- Write collision: channels 1 and 3 both write addr 0x20 (data 0xAA, 0xBB) in the same cycle → after the gets, host_rd_data@0x20=0xAA.
- Read/write race: mem[0x30]=0x01; channel 0 write 0x02 and channel 2 read at 0x30 accepted in the same cycle → read returns 0x01; a subsequent read returns 0x02.
- Held ask: channel 0 keeps read_ask high continuously with LATENCY=1 → gets spaced exactly 3 cycles apart (LATENCY+2).
- Reset mid-flight: assert reset one cycle after accepting a write of 0x77 to 0x40 (previously 0x00) → no write_get; mem[0x40] stays 0x00; all gets stay 0 during reset.
